btn_scan_ctrl: RTL and testbench



---
 rtl/btn_scan_pkg.sv | 9 +
 rtl/btn_sync2.sv | 27 ++
 rtl/btn_scan_ctrl.sv | 116 +++++++++++
 tb/tb_btn_scan_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_scan_pkg.sv
// btn_scan_pkg: shared state encoding and default sizing for the button scan controller
package btn_scan_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, COMMIT} state_t;

    localparam int BTN_N_DEFAULT    = 4;
    localparam int DEBOUNCE_DEFAULT = 131072;

endpackage

// File: rtl/btn_sync2.sv
// btn_sync2: W-bit two-flop synchroniser for asynchronous inputs
//   clk_100MHz : sampling clock
//   rst        : asynchronous active-high reset, clears both stages to 0
//   d          : asynchronous input vector
//   q          : synchronised output vector (two clocks of latency)
module btn_sync2 #(
    parameter int W = 4
) (
    input  logic         clk_100MHz,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_scan_ctrl.sv
// btn_scan_ctrl: debounces N_BTN buttons with one shared timer, served round-robin
//   clk_100MHz  : system clock, rising edge
//   rst         : asynchronous active-high reset
//   btn         : raw button levels, 1 = pressed
//   btn_level   : debounced level per button
//   btn_press   : one-cycle pulse on an accepted 0->1
//   btn_release : one-cycle pulse on an accepted 1->0
//   busy        : high while a button is being timed or committed
//   cur_sel     : index of the button being timed, valid while busy
module btn_scan_ctrl
    import btn_scan_pkg::*;
#(
    parameter int N_BTN           = BTN_N_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 22,
    parameter int SEL_W           = $clog2(N_BTN)
) (
    input  logic             clk_100MHz,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             busy,
    output logic [SEL_W-1:0] cur_sel
);

    state_t           state, state_n;
    logic [SEL_W-1:0] ptr, ptr_n, sel_n;
    logic [CNT_W-1:0] timer, timer_n;
    logic [N_BTN-1:0] sync, pending, level_n, press_n, release_n;

    btn_sync2 #(.W(N_BTN)) u_sync (
        .clk_100MHz(clk_100MHz),
        .rst(rst),
        .d(btn),
        .q(sync)
    );

    assign pending = sync ^ btn_level;
    assign busy    = state != IDLE;

    function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] s);
        return (s == SEL_W'(N_BTN - 1)) ? '0 : s + SEL_W'(1);
    endfunction

    // Scan downwards from the farthest offset so the nearest pending index
    // at or after start (modulo N_BTN) is the one left standing.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_BTN-1:0] req,
                                                 input logic [SEL_W-1:0] start);
        logic [SEL_W-1:0] idx;
        rr_pick = start;
        for (int k = N_BTN - 1; k >= 0; k--) begin
            idx = SEL_W'((int'(start) + k) % N_BTN);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        sel_n     = cur_sel;
        timer_n   = timer;
        level_n   = btn_level;
        press_n   = '0;
        release_n = '0;
        case (state)
            IDLE: begin
                if (|pending) begin
                    sel_n   = rr_pick(pending, ptr);
                    timer_n = '0;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (sync[cur_sel] == btn_level[cur_sel]) begin
                    state_n = IDLE;
                    ptr_n   = next_sel(cur_sel);
                end else if (timer == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_n = COMMIT;
                end else begin
                    timer_n = timer + CNT_W'(1);
                end
            end
            COMMIT: begin
                level_n[cur_sel]   = sync[cur_sel];
                press_n[cur_sel]   = sync[cur_sel];
                release_n[cur_sel] = ~sync[cur_sel];
                ptr_n              = next_sel(cur_sel);
                state_n            = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            cur_sel     <= '0;
            timer       <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            cur_sel     <= sel_n;
            timer       <= timer_n;
            btn_level   <= level_n;
            btn_press   <= press_n;
            btn_release <= release_n;
        end
    end

endmodule

// File: tb/tb_btn_scan_ctrl.sv
// tb_btn_scan_ctrl: directed scenarios plus a randomized run checked against a window-based reference model
module tb_btn_scan_ctrl;

    localparam int N  = 4;
    localparam int D  = 16;
    localparam int CW = 5;
    localparam int NR = 3000;

    logic         clk_100MHz = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn = '0;
    logic [N-1:0] btn_level, btn_press, btn_release;
    logic         busy;
    logic [1:0]   cur_sel;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    logic [N-1:0] raw   [NR];
    logic [N-1:0] obs_p [NR];
    logic [N-1:0] obs_r [NR];
    logic [N-1:0] obs_l [NR];
    logic         obs_b [NR];
    logic [1:0]   obs_s [NR];
    logic [N-1:0] exp_p [NR];
    logic [N-1:0] exp_r [NR];
    logic [N-1:0] exp_l [NR];
    logic         exp_b [NR];
    int           exp_s [NR];

    btn_scan_ctrl #(.N_BTN(N), .DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
        .clk_100MHz(clk_100MHz),
        .rst(rst),
        .btn(btn),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release),
        .busy(busy),
        .cur_sel(cur_sel)
    );

    always #5 clk_100MHz = ~clk_100MHz;
    always @(posedge clk_100MHz) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int k);
        repeat (k) @(negedge clk_100MHz);
    endtask

    task automatic wait_pulse(input int idx, input bit rel, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit && at < 0; i++) begin
            @(negedge clk_100MHz);
            if ((rel ? btn_release[idx] : btn_press[idx]) === 1'b1) at = cyc;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        btn = '0;
        step(3);
        n_cmp++;
        if ({btn_level, btn_press, btn_release, busy, cur_sel} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %b want 0", {btn_level, btn_press, btn_release, busy, cur_sel});
        end
        rst = 1'b0;
        step(3);
        n_cmp++;
        if (busy !== 1'b0 || btn_level !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_idle: busy=%b level=%b want 0/0000", busy, btn_level);
        end
    endtask

    task automatic test_simultaneous;
        int c0, a0, a3;
        c0 = cyc;
        btn = 4'b1001;
        wait_pulse(0, 1'b0, 60, a0);
        n_cmp++;
        if (a0 != c0 + D + 4) begin
            n_bad++;
            $display("FAIL sim_first_latency: got cycle %0d want %0d", a0, c0 + D + 4);
        end
        n_cmp++;
        if (btn_press !== 4'b0001 || btn_release !== 4'b0000) begin
            n_bad++;
            $display("FAIL sim_first_pulse: press=%b release=%b want 0001/0000", btn_press, btn_release);
        end
        step(1);
        n_cmp++;
        if (btn_press !== 4'b0000 || busy !== 1'b1 || cur_sel !== 2'd3 || btn_level !== 4'b0001) begin
            n_bad++;
            $display("FAIL sim_second_start: press=%b busy=%b sel=%0d level=%b want 0000/1/3/0001",
                     btn_press, busy, cur_sel, btn_level);
        end
        wait_pulse(3, 1'b0, 60, a3);
        n_cmp++;
        if (a3 != a0 + D + 2) begin
            n_bad++;
            $display("FAIL sim_second_latency: got cycle %0d want %0d", a3, a0 + D + 2);
        end
        n_cmp++;
        if (btn_press !== 4'b1000 || btn_level !== 4'b1001) begin
            n_bad++;
            $display("FAIL sim_second_pulse: press=%b level=%b want 1000/1001", btn_press, btn_level);
        end
        step(1);
        n_cmp++;
        if (btn_press !== 4'b0000) begin
            n_bad++;
            $display("FAIL sim_pulse_width: press=%b want 0000", btn_press);
        end
    endtask

    task automatic test_press;
        int c0, a;
        c0 = cyc;
        btn = 4'b1011;
        wait_pulse(1, 1'b0, 60, a);
        n_cmp++;
        if (a != c0 + D + 4) begin
            n_bad++;
            $display("FAIL press_latency: got cycle %0d want %0d", a, c0 + D + 4);
        end
        n_cmp++;
        if (btn_press !== 4'b0010 || btn_level !== 4'b1011) begin
            n_bad++;
            $display("FAIL press_pulse: press=%b level=%b want 0010/1011", btn_press, btn_level);
        end
        step(1);
        n_cmp++;
        if (btn_press !== 4'b0000 || btn_level !== 4'b1011) begin
            n_bad++;
            $display("FAIL press_width: press=%b level=%b want 0000/1011", btn_press, btn_level);
        end
    endtask

    task automatic test_abort;
        int bad;
        btn = 4'b1111;
        step(8);
        n_cmp++;
        if (busy !== 1'b1 || cur_sel !== 2'd2) begin
            n_bad++;
            $display("FAIL abort_wait: busy=%b sel=%0d want 1/2", busy, cur_sel);
        end
        btn = 4'b1011;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if ((btn_press | btn_release) !== 4'b0000) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL abort_no_pulse: got %0d pulse cycles want 0", bad);
        end
        n_cmp++;
        if (busy !== 1'b0 || btn_level !== 4'b1011) begin
            n_bad++;
            $display("FAIL abort_idle: busy=%b level=%b want 0/1011", busy, btn_level);
        end
    endtask

    task automatic test_round_robin;
        logic [7:0] rr_exp [4];
        int got;
        rr_exp = '{8'b0000_1000, 8'b0000_0001, 8'b0000_0010, 8'b0100_0000};
        got = 0;
        btn = 4'b0100;
        for (int i = 0; i < 4 * (D + 2) + 20; i++) begin
            step(1);
            if ((btn_press | btn_release) !== 4'b0000) begin
                if (got < 4) begin
                    n_cmp++;
                    if ({btn_press, btn_release} !== rr_exp[got]) begin
                        n_bad++;
                        $display("FAIL rr_order_%0d: press/release=%b want %b", got, {btn_press, btn_release}, rr_exp[got]);
                    end
                end
                got++;
            end
        end
        n_cmp++;
        if (got != 4 || btn_level !== 4'b0100) begin
            n_bad++;
            $display("FAIL rr_count: pulses=%0d level=%b want 4/0100", got, btn_level);
        end
    endtask

    task automatic test_reset_mid_wait;
        int m, a;
        btn = 4'b0000;
        step(D + 10);
        n_cmp++;
        if (btn_level !== 4'b0000) begin
            n_bad++;
            $display("FAIL rst_setup: level=%b want 0000", btn_level);
        end
        btn = 4'b0100;
        step(8);
        n_cmp++;
        if (busy !== 1'b1 || cur_sel !== 2'd2) begin
            n_bad++;
            $display("FAIL rst_wait: busy=%b sel=%0d want 1/2", busy, cur_sel);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({btn_level, btn_press, btn_release, busy, cur_sel} !== 15'd0) begin
            n_bad++;
            $display("FAIL rst_async_clear: got %b want 0", {btn_level, btn_press, btn_release, busy, cur_sel});
        end
        step(2);
        rst = 1'b0;
        m = cyc;
        wait_pulse(2, 1'b0, 60, a);
        n_cmp++;
        if (a != m + D + 4 || btn_press !== 4'b0100) begin
            n_bad++;
            $display("FAIL rst_repress: got cycle %0d press=%b want %0d/0100", a, btn_press, m + D + 4);
        end
    endtask

    task automatic test_chatter;
        int s, first, p0;
        s = cyc;
        first = -1;
        p0 = 0;
        btn = 4'b0111;
        for (int i = 1; i <= 80; i++) begin
            step(1);
            if (btn_press[1] === 1'b1 && first < 0) first = cyc;
            if (btn_press[0] === 1'b1) p0++;
            if (i % 4 == 0) btn[0] = ~btn[0];
        end
        btn[0] = 1'b0;
        n_cmp++;
        if (first < 0 || first - s > 2 * (D + 2) + 4) begin
            n_bad++;
            $display("FAIL chatter_fair: press1 after %0d cycles want <= %0d", first < 0 ? -1 : first - s, 2 * (D + 2) + 4);
        end
        n_cmp++;
        if (p0 != 0) begin
            n_bad++;
            $display("FAIL chatter_no_press0: got %0d want 0", p0);
        end
        step(D + 10);
        n_cmp++;
        if (btn_level !== 4'b0110) begin
            n_bad++;
            $display("FAIL chatter_level: level=%b want 0110", btn_level);
        end
    endtask

    function automatic logic [N-1:0] sync_at(input int c);
        return (c >= 2 && c - 2 < NR) ? raw[c-2] : '0;
    endfunction

    // Reference: whenever the controller is free it takes the first pending
    // button from ptr; the window that follows either breaks at the first
    // cycle the button reads its old level, or lasts D cycles and commits.
    task automatic build_model;
        int t, ptr, b, ab;
        logic [N-1:0] lvl, pend, sv;
        for (int c = 0; c < NR; c++) begin
            exp_p[c] = '0;
            exp_r[c] = '0;
            exp_l[c] = '0;
            exp_b[c] = 1'b0;
            exp_s[c] = 0;
        end
        t = 0;
        ptr = 0;
        lvl = '0;
        while (t < NR) begin
            exp_l[t] = lvl;
            pend = sync_at(t) ^ lvl;
            if (pend == '0) begin
                t++;
            end else begin
                b = -1;
                for (int k = 0; k < N && b < 0; k++) if (pend[(ptr + k) % N]) b = (ptr + k) % N;
                ab = -1;
                for (int c = t + 1; c <= t + D && c < NR && ab < 0; c++) begin
                    exp_b[c] = 1'b1;
                    exp_s[c] = b;
                    exp_l[c] = lvl;
                    sv = sync_at(c);
                    if (sv[b] == lvl[b]) ab = c;
                end
                ptr = (b + 1) % N;
                if (ab >= 0) begin
                    t = ab + 1;
                end else begin
                    if (t + D + 1 < NR) begin
                        exp_b[t+D+1] = 1'b1;
                        exp_s[t+D+1] = b;
                        exp_l[t+D+1] = lvl;
                    end
                    sv = sync_at(t + D + 1);
                    if (t + D + 2 < NR) begin
                        exp_p[t+D+2][b] = sv[b];
                        exp_r[t+D+2][b] = ~sv[b];
                    end
                    lvl[b] = sv[b];
                    t = t + D + 2;
                end
            end
        end
    endtask

    task automatic test_random;
        int hold [N];
        logic [N-1:0] cur;
        rst = 1'b1;
        btn = '0;
        cur = '0;
        for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 30);
        step(3);
        rst = 1'b0;
        for (int k = 0; k < NR; k++) begin
            if (k > 0) step(1);
            obs_p[k] = btn_press;
            obs_r[k] = btn_release;
            obs_l[k] = btn_level;
            obs_b[k] = busy;
            obs_s[k] = cur_sel;
            for (int i = 0; i < N; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    cur[i] = ~cur[i];
                    hold[i] = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 8) : $urandom_range(18, 45);
                end
            end
            raw[k] = cur;
            btn = cur;
        end
        build_model();
        for (int c = 0; c < NR; c++) begin
            n_cmp++;
            if (obs_p[c] !== exp_p[c] || obs_r[c] !== exp_r[c] || obs_l[c] !== exp_l[c] ||
                obs_b[c] !== exp_b[c] || (exp_b[c] && int'(obs_s[c]) != exp_s[c])) begin
                n_bad++;
                $display("FAIL rand_cycle_%0d: p=%b r=%b l=%b b=%b s=%0d want p=%b r=%b l=%b b=%b s=%0d",
                         c, obs_p[c], obs_r[c], obs_l[c], obs_b[c], obs_s[c],
                         exp_p[c], exp_r[c], exp_l[c], exp_b[c], exp_s[c]);
            end
            n_cmp++;
            if ($countones(obs_p[c] | obs_r[c]) > 1) begin
                n_bad++;
                $display("FAIL rand_onehot_%0d: p=%b r=%b want at most one bit", c, obs_p[c], obs_r[c]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_press();
        test_abort();
        test_round_robin();
        test_reset_mid_wait();
        test_chatter();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
